dram_tile_rd_seq: RTL and testbench

//  Issues DRAM read bursts for weight tiles into the DRAM front-end FIFO master port
//  (sprambus-style rdreq/address/ready/info). The block sits directly upstream of that FIFO.
//  It takes one command: base address, tile count, words per tile and tile stride.
//  It walks the command word by word and tags the first word of each tile with new_tile_k.

---
 rtl/dram_tile_rd_seq_if.sv | 41 ++++
 rtl/dram_tile_rd_seq.sv | 188 ++++++++++++++++++
 tb/tb_dram_tile_rd_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_tile_rd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : dram_tile_rd_seq_if
//  Description : Command and DRAM front-end master-port signals for the
//                tile read sequencer. The master modport is the sequencer's
//                view; the slave modport is the command source / FIFO side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dram_tile_rd_seq_if #(
  parameter int ADDR_W = 27,
  parameter int CNT_W  = 16
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_ntiles;
  logic [CNT_W-1:0]  cmd_tile_words;
  logic [ADDR_W-1:0] cmd_stride;

  // DRAM front-end master port
  logic              ready;
  logic              rdreq;
  logic [ADDR_W-1:0] address;
  logic              info_valid;
  logic              info_new_tile_k;
  logic              q_valid;

  modport master (
    input  cmd_valid, cmd_base, cmd_ntiles, cmd_tile_words, cmd_stride,
    input  ready, q_valid,
    output cmd_ready, rdreq, address, info_valid, info_new_tile_k
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_ntiles, cmd_tile_words, cmd_stride,
    output ready, q_valid,
    input  cmd_ready, rdreq, address, info_valid, info_new_tile_k
  );
endinterface
`default_nettype wire

// File: rtl/dram_tile_rd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dram_tile_rd_seq
//  Description : Walks one tile-read command word by word and issues DRAM
//                read requests into the front-end FIFO master port, tagging
//                the first word of each tile. Returned words free credits so
//                no more than CREDITS reads are ever in flight.
//  Options     : DRAM_RD_SEQ_PERF_EN adds stall_cycles / credit_stalls
//                saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_tile_rd_seq #(
  parameter int ADDR_W  = 27,
  parameter int CNT_W   = 16,
  parameter int CREDITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  dram_tile_rd_seq_if.master  seq_if,
  output logic                busy,
  output logic                done,
  output logic                err_underflow
`ifdef DRAM_RD_SEQ_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         credit_stalls
`endif
);

  localparam int                 c_OUT_W   = $clog2(CREDITS + 1);
  localparam logic [c_OUT_W-1:0] c_CREDITS = c_OUT_W'(CREDITS);
  localparam logic [c_OUT_W-1:0] c_OUT_ONE = c_OUT_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_tile_addr;
  logic [ADDR_W-1:0]   r_stride;
  logic [CNT_W-1:0]    r_ntiles;
  logic [CNT_W-1:0]    r_tile_words;
  logic [CNT_W-1:0]    r_tile;
  logic [CNT_W-1:0]    r_word;
  logic [c_OUT_W-1:0]  r_outstanding;
  logic                r_err;

  logic                w_accept;
  logic                w_rdreq;
  logic                w_credit_ok;
  logic                w_last_word;
  logic                w_last_tile;

  assign w_credit_ok = (r_outstanding < c_CREDITS);
  assign w_last_word = (r_word == (r_tile_words - c_CNT_ONE));
  assign w_last_tile = (r_tile == (r_ntiles - c_CNT_ONE));

  // Next-state and handshake decode; issue depends only on registered state
  // plus the live ready, so a stalled request holds nothing.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rdreq     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = seq_if.cmd_valid;
        if (w_accept) begin
          w_state_nxt = (seq_if.cmd_ntiles != '0) ? ST_RUN : ST_DRAIN;
        end
      end
      ST_RUN: begin
        w_rdreq = seq_if.ready & w_credit_ok;
        if (w_rdreq && w_last_word && w_last_tile) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_outstanding == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command latch and tile/word walk; address wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tile_addr  <= '0;
      r_stride     <= '0;
      r_ntiles     <= '0;
      r_tile_words <= '0;
      r_tile       <= '0;
      r_word       <= '0;
    end else if (w_accept) begin
      r_tile_addr  <= seq_if.cmd_base;
      r_stride     <= seq_if.cmd_stride;
      r_ntiles     <= seq_if.cmd_ntiles;
      r_tile_words <= (seq_if.cmd_tile_words == '0) ? c_CNT_ONE : seq_if.cmd_tile_words;
      r_tile       <= '0;
      r_word       <= '0;
    end else if (w_rdreq) begin
      if (w_last_word) begin
        r_word      <= '0;
        r_tile      <= r_tile + c_CNT_ONE;
        r_tile_addr <= r_tile_addr + r_stride;
      end else begin
        r_word      <= r_word + c_CNT_ONE;
      end
    end
  end

  // In-flight read count; a return with nothing in flight is flagged sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_rdreq && !seq_if.q_valid) begin
        r_outstanding <= r_outstanding + c_OUT_ONE;
      end else if (!w_rdreq && seq_if.q_valid) begin
        if (r_outstanding == '0) begin
          r_err <= 1'b1;
        end else begin
          r_outstanding <= r_outstanding - c_OUT_ONE;
        end
      end
    end
  end

`ifdef DRAM_RD_SEQ_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_credit_stalls;

  // Saturating stall counters, restarted for every accepted command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles  <= '0;
      r_credit_stalls <= '0;
    end else if (w_accept) begin
      r_stall_cycles  <= '0;
      r_credit_stalls <= '0;
    end else if (r_state == ST_RUN) begin
      if (!w_rdreq && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (seq_if.ready && !w_credit_ok && (r_credit_stalls != 32'hFFFF_FFFF)) begin
        r_credit_stalls <= r_credit_stalls + 32'd1;
      end
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign credit_stalls = r_credit_stalls;
`endif

  assign seq_if.cmd_ready       = (r_state == ST_IDLE);
  assign seq_if.rdreq           = w_rdreq;
  assign seq_if.info_valid      = w_rdreq;
  assign seq_if.info_new_tile_k = w_rdreq & (r_word == '0);
  assign seq_if.address         = r_tile_addr + ADDR_W'(r_word);

  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_tile_rd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_tile_rd_seq
//  Description : Directed self-checking bench for dram_tile_rd_seq. Instance
//                a uses 32 credits, instance b uses 2 credits.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_tile_rd_seq;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic busy_a, done_a, err_a;
  logic busy_b, done_b, err_b;
`ifdef DRAM_RD_SEQ_PERF_EN
  logic [31:0] stall_a, cstall_a, stall_b, cstall_b;
`endif

  int checks = 0;
  int errors = 0;

  dram_tile_rd_seq_if #(.ADDR_W(27), .CNT_W(16)) bus_a ();
  dram_tile_rd_seq_if #(.ADDR_W(27), .CNT_W(16)) bus_b ();

  dram_tile_rd_seq #(.ADDR_W(27), .CNT_W(16), .CREDITS(32)) dut_a (
    .clk(clk), .reset(rst_a), .seq_if(bus_a),
    .busy(busy_a), .done(done_a), .err_underflow(err_a)
`ifdef DRAM_RD_SEQ_PERF_EN
    , .stall_cycles(stall_a), .credit_stalls(cstall_a)
`endif
  );

  dram_tile_rd_seq #(.ADDR_W(27), .CNT_W(16), .CREDITS(2)) dut_b (
    .clk(clk), .reset(rst_b), .seq_if(bus_b),
    .busy(busy_b), .done(done_b), .err_underflow(err_b)
`ifdef DRAM_RD_SEQ_PERF_EN
    , .stall_cycles(stall_b), .credit_stalls(cstall_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus_a.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_a got %b exp 1", bus_a.cmd_ready); end
    checks++; if (bus_a.rdreq !== 1'b0 || bus_a.info_valid !== 1'b0 || bus_a.info_new_tile_k !== 1'b0) begin errors++; $display("FAIL reset_req_a got %b%b%b exp 000", bus_a.rdreq, bus_a.info_valid, bus_a.info_new_tile_k); end
    checks++; if (bus_a.address !== 27'h0) begin errors++; $display("FAIL reset_addr_a got %h exp 0", bus_a.address); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin errors++; $display("FAIL reset_status_a got %b%b%b exp 000", busy_a, done_a, err_a); end
    checks++; if (bus_b.cmd_ready !== 1'b1 || bus_b.rdreq !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL reset_b got rdy=%b rd=%b busy=%b err=%b", bus_b.cmd_ready, bus_b.rdreq, busy_b, err_b); end
`ifdef DRAM_RD_SEQ_PERF_EN
    checks++; if (stall_a !== 32'd0 || cstall_a !== 32'd0) begin errors++; $display("FAIL reset_perf_a got %0d/%0d exp 0/0", stall_a, cstall_a); end
`endif
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  // base 0x100, 2 tiles x 4 words, stride 0x40, returns 3 cycles after issue
  task automatic test_tile_walk();
    logic [26:0] exp_addr;
    logic        exp_rd;
    @(negedge clk);
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_base = 27'h100; bus_a.cmd_ntiles = 16'd2; bus_a.cmd_tile_words = 16'd4; bus_a.cmd_stride = 27'h40;
    bus_a.ready = 1'b1;
    #1;
    checks++; if (bus_a.cmd_ready !== 1'b1) begin errors++; $display("FAIL walk_cmd_ready got %b exp 1", bus_a.cmd_ready); end
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus_a.cmd_valid = 1'b0;
      bus_a.q_valid = (c >= 4 && c <= 11);
      #1;
      exp_rd = (c >= 1 && c <= 8);
      exp_addr = 27'h100 + 27'((c - 1) / 4) * 27'h40 + 27'((c - 1) % 4);
      checks++; if (bus_a.rdreq !== exp_rd || bus_a.info_valid !== exp_rd) begin errors++; $display("FAIL walk_rdreq c=%0d got %b/%b exp %b", c, bus_a.rdreq, bus_a.info_valid, exp_rd); end
      if (exp_rd) begin
        checks++; if (bus_a.address !== exp_addr) begin errors++; $display("FAIL walk_addr c=%0d got %h exp %h", c, bus_a.address, exp_addr); end
        checks++; if (bus_a.info_new_tile_k !== (((c - 1) % 4) == 0)) begin errors++; $display("FAIL walk_new_tile c=%0d got %b exp %b", c, bus_a.info_new_tile_k, (((c - 1) % 4) == 0)); end
      end
      checks++; if (done_a !== (c == 13)) begin errors++; $display("FAIL walk_done c=%0d got %b exp %b", c, done_a, (c == 13)); end
      checks++; if (busy_a !== (c <= 13)) begin errors++; $display("FAIL walk_busy c=%0d got %b exp %b", c, busy_a, (c <= 13)); end
    end
    bus_a.q_valid = 1'b0;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL walk_err got %b exp 0", err_a); end
`ifdef DRAM_RD_SEQ_PERF_EN
    checks++; if (stall_a !== 32'd0 || cstall_a !== 32'd0) begin errors++; $display("FAIL walk_perf got %0d/%0d exp 0/0", stall_a, cstall_a); end
`endif
  endtask

  // 2 credits: two issues then stall; one return frees one issue;
  // a return coinciding with an issue leaves the in-flight count unchanged
  task automatic test_credit_limit();
    logic        exp_rd;
    logic [26:0] exp_addr;
    @(negedge clk);
    bus_b.cmd_valid = 1'b1;
    bus_b.cmd_base = 27'h2000; bus_b.cmd_ntiles = 16'd1; bus_b.cmd_tile_words = 16'd8; bus_b.cmd_stride = 27'h0;
    bus_b.ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus_b.cmd_valid = 1'b0;
      bus_b.q_valid = (c == 6 || c == 7);
      #1;
      exp_rd = (c == 1 || c == 2 || c == 7 || c == 8);
      exp_addr = (c == 1) ? 27'h2000 : (c == 2) ? 27'h2001 : (c == 7) ? 27'h2002 : 27'h2003;
      checks++; if (bus_b.rdreq !== exp_rd) begin errors++; $display("FAIL credit_rdreq c=%0d got %b exp %b", c, bus_b.rdreq, exp_rd); end
      if (exp_rd) begin
        checks++; if (bus_b.address !== exp_addr) begin errors++; $display("FAIL credit_addr c=%0d got %h exp %h", c, bus_b.address, exp_addr); end
      end
`ifdef DRAM_RD_SEQ_PERF_EN
      if (c == 6) begin
        checks++; if (cstall_b !== 32'd3) begin errors++; $display("FAIL credit_stalls got %0d exp 3", cstall_b); end
        checks++; if (stall_b !== 32'd3) begin errors++; $display("FAIL credit_stall_cycles got %0d exp 3", stall_b); end
      end
`endif
    end
    bus_b.q_valid = 1'b0;
    checks++; if (err_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL credit_status got err=%b busy=%b exp 0/1", err_b, busy_b); end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_zero_tiles();
    @(negedge clk);
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_base = 27'h300; bus_a.cmd_ntiles = 16'd0; bus_a.cmd_tile_words = 16'd5; bus_a.cmd_stride = 27'h10;
    bus_a.ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus_a.cmd_valid = 1'b0;
      #1;
      checks++; if (bus_a.rdreq !== 1'b0) begin errors++; $display("FAIL zero_rdreq c=%0d got %b exp 0", c, bus_a.rdreq); end
      checks++; if (done_a !== (c == 2)) begin errors++; $display("FAIL zero_done c=%0d got %b exp %b", c, done_a, (c == 2)); end
      checks++; if (busy_a !== (c <= 2) || bus_a.cmd_ready !== (c >= 3)) begin errors++; $display("FAIL zero_busy c=%0d got busy=%b rdy=%b", c, busy_a, bus_a.cmd_ready); end
    end
  endtask

  // address wrap at 2^27 with ready toggling every cycle
  task automatic test_wrap_toggle();
    logic [26:0] exp4 [4];
    logic        exp_rd;
    int          idx;
    exp4[0] = 27'h7FF_FFFE; exp4[1] = 27'h7FF_FFFF; exp4[2] = 27'h0; exp4[3] = 27'h1;
    idx = 0;
    @(negedge clk);
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_base = 27'h7FF_FFFE; bus_a.cmd_ntiles = 16'd1; bus_a.cmd_tile_words = 16'd4; bus_a.cmd_stride = 27'h0;
    bus_a.ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus_a.cmd_valid = 1'b0;
      bus_a.ready = ((c % 2) == 1);
      #1;
      exp_rd = bus_a.ready && (idx < 4);
      checks++; if (bus_a.rdreq !== exp_rd) begin errors++; $display("FAIL wrap_rdreq c=%0d got %b exp %b", c, bus_a.rdreq, exp_rd); end
      if (idx < 4) begin
        checks++; if (bus_a.address !== exp4[idx]) begin errors++; $display("FAIL wrap_addr c=%0d got %h exp %h", c, bus_a.address, exp4[idx]); end
      end
      if (exp_rd) begin
        checks++; if (bus_a.info_new_tile_k !== (idx == 0)) begin errors++; $display("FAIL wrap_new_tile c=%0d got %b exp %b", c, bus_a.info_new_tile_k, (idx == 0)); end
        idx++;
      end
    end
    for (int c = 9; c <= 15; c++) begin
      @(negedge clk);
      bus_a.ready = 1'b1;
      bus_a.q_valid = (c <= 12);
      #1;
      checks++; if (bus_a.rdreq !== 1'b0) begin errors++; $display("FAIL wrap_drain_rdreq c=%0d got %b exp 0", c, bus_a.rdreq); end
      checks++; if (done_a !== (c == 14)) begin errors++; $display("FAIL wrap_done c=%0d got %b exp %b", c, done_a, (c == 14)); end
    end
    bus_a.q_valid = 1'b0;
    checks++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL wrap_status got err=%b busy=%b exp 0/0", err_a, busy_a); end
`ifdef DRAM_RD_SEQ_PERF_EN
    checks++; if (stall_a !== 32'd3 || cstall_a !== 32'd0) begin errors++; $display("FAIL wrap_perf got %0d/%0d exp 3/0", stall_a, cstall_a); end
`endif
  endtask

  task automatic test_underflow_idle();
    @(negedge clk);
    bus_a.q_valid = 1'b1;
    #1;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL uflow_pre got %b exp 0", err_a); end
    @(negedge clk);
    bus_a.q_valid = 1'b0;
    #1;
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL uflow_set got %b exp 1", err_a); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL uflow_sticky got err=%b busy=%b exp 1/0", err_a, busy_a); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_base = 27'h500; bus_a.cmd_ntiles = 16'd1; bus_a.cmd_tile_words = 16'd8; bus_a.cmd_stride = 27'h0;
    bus_a.ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus_a.cmd_valid = 1'b0;
      #1;
      checks++; if (bus_a.rdreq !== 1'b1 || bus_a.address !== 27'h500 + 27'(c - 1)) begin errors++; $display("FAIL rst_run c=%0d got rd=%b addr=%h exp 1/%h", c, bus_a.rdreq, bus_a.address, 27'h500 + 27'(c - 1)); end
`ifdef DRAM_RD_SEQ_PERF_EN
      if (c == 1) begin
        checks++; if (stall_a !== 32'd0) begin errors++; $display("FAIL rst_perf_clear got %0d exp 0", stall_a); end
      end
`endif
    end
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    checks++; if (bus_a.rdreq !== 1'b0 || busy_a !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_immediate got rd=%b busy=%b rdy=%b exp 0/0/1", bus_a.rdreq, busy_a, bus_a.cmd_ready); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rst_err_clear got %b exp 0", err_a); end
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    bus_a.q_valid = 1'b1;
    @(negedge clk);
    bus_a.q_valid = 1'b0;
    #1;
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL rst_late_return got %b exp 1", err_a); end
    @(negedge clk);
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_base = 27'h900; bus_a.cmd_ntiles = 16'd1; bus_a.cmd_tile_words = 16'd2; bus_a.cmd_stride = 27'h0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus_a.cmd_valid = 1'b0;
      #1;
      checks++; if (bus_a.rdreq !== (c <= 2)) begin errors++; $display("FAIL restart_rdreq c=%0d got %b exp %b", c, bus_a.rdreq, (c <= 2)); end
      if (c <= 2) begin
        checks++; if (bus_a.address !== 27'h900 + 27'(c - 1) || bus_a.info_new_tile_k !== (c == 1)) begin errors++; $display("FAIL restart_addr c=%0d got %h/%b exp %h/%b", c, bus_a.address, bus_a.info_new_tile_k, 27'h900 + 27'(c - 1), (c == 1)); end
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_base = '0; bus_a.cmd_ntiles = '0; bus_a.cmd_tile_words = '0; bus_a.cmd_stride = '0;
    bus_a.ready = 1'b0; bus_a.q_valid = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_base = '0; bus_b.cmd_ntiles = '0; bus_b.cmd_tile_words = '0; bus_b.cmd_stride = '0;
    bus_b.ready = 1'b0; bus_b.q_valid = 1'b0;
    test_reset();
    test_tile_walk();
    test_credit_limit();
    test_zero_tiles();
    test_wrap_toggle();
    test_underflow_idle();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
